// File: rtl/basic_ram_pkg.sv
// rtl/basic_ram_pkg.sv - shared types and constants for the basic_ram block
package basic_ram_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/basic_ram.sv
// rtl/basic_ram.sv - word-addressed RAM with fixed access latency and done pulse
module basic_ram
  import basic_ram_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [31:0]       address,
  output logic [DATA_W-1:0] data_output,
  input  logic [DATA_W-1:0] data_input,
  output logic              mem_done,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic              rst_n
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic              accept;
  logic              commit;

  // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (cs && (we || oe)) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter loads LATENCY-1 so the commit edge lands exactly LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_done    <= 1'b0;
      data_output <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_done <= commit;
      if (accept) begin
        lat_addr  <= address[AW-1:0];
        lat_data  <= data_input;
        lat_write <= we;
        cnt       <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && !lat_write) begin
        data_output <= mem[lat_addr];
      end
    end
  end

  // No reset on the array: contents survive reset and the port stays BRAM-friendly.
  always_ff @(posedge clk) begin
    if (commit && lat_write) begin
      mem[lat_addr] <= lat_data;
    end
  end

endmodule

// File: tb/tb_basic_ram.sv
// tb/tb_basic_ram.sv - directed self-checking bench for basic_ram
module tb_basic_ram;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] data_output;
  logic [31:0] data_input;
  logic        mem_done;
  logic        cs;
  logic        we;
  logic        oe;

  int errors = 0;
  int checks = 0;

  basic_ram #(.DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")) dut (
    .clk        (clk),
    .address    (address),
    .data_output(data_output),
    .data_input (data_input),
    .mem_done   (mem_done),
    .cs         (cs),
    .we         (we),
    .oe         (oe),
    .rst_n      (rst_n)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles inputs while it is in flight, and reports
  // the number of edges from acceptance to mem_done (0 if it never came).
  task automatic do_op(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic o, output int lat);
    cs = 1'b1; we = w; oe = o; address = a; data_input = d;
    @(posedge clk); #1;
    cs = 1'b0; we = ~w; oe = ~o; address = $urandom; data_input = $urandom;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_done) begin
        lat = i;
        break;
      end
    end
    we = 1'b0; oe = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_done !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: mem_done=%b required 0 one cycle after pulse", mem_done);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    checks++;
    if (lat !== LATENCY) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, LATENCY);
    end
  endtask

  task automatic check_dout(input string name, input logic [31:0] exp);
    checks++;
    if (data_output !== exp) begin
      errors++;
      $display("FAIL %s: data_output=%h required %h", name, data_output, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; address = '0; data_input = '0;
    #2;
    check_dout("reset_dout", 32'h0);
    checks++;
    if (mem_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: mem_done=%b required 0", mem_done);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle;
    int seen = 0;
    cs = 1'b0; we = 1'b1; oe = 1'b1; address = 32'd2; data_input = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_done) seen++;
    end
    we = 1'b0; oe = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL idle_no_cs: saw %0d pulses required 0", seen);
    end
  endtask

  task automatic test_write_read;
    int lat;
    do_op(32'd0, 32'h0102_0304, 1'b1, 1'b0, lat);
    check_lat("write0", lat);
    check_dout("write0_dout_hold", 32'h0);
    do_op(32'd0, 32'h0, 1'b0, 1'b1, lat);
    check_lat("read0", lat);
    check_dout("read0_data", 32'h0102_0304);
  endtask

  task automatic test_we_oe;
    int lat;
    do_op(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, lat);
    check_lat("weoe_write", lat);
    check_dout("weoe_dout_hold", 32'h0102_0304);
    do_op(32'd5, 32'h0, 1'b0, 1'b1, lat);
    check_dout("weoe_read5", 32'hDEAD_BEEF);
  endtask

  task automatic test_wrap;
    int lat;
    do_op(DEPTH + 3, 32'hAAAA_5555, 1'b1, 1'b0, lat);
    do_op(32'd3, 32'h0, 1'b0, 1'b1, lat);
    check_dout("wrap_read3", 32'hAAAA_5555);
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen = 0;
    do_op(32'd7, 32'h1111_1111, 1'b1, 1'b0, lat);
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'd7; data_input = 32'h1234_5678;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_dout("abort_dout_reset", 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_done) seen++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: saw %0d pulses required 0", seen);
    end
    do_op(32'd7, 32'h0, 1'b0, 1'b1, lat);
    check_dout("abort_read7", 32'h1111_1111);
  endtask

  task automatic test_back_to_back;
    int pulses[$];
    int lat;
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = 32'd9;
    for (int e = 1; e <= 20; e++) begin
      data_input = 32'hC000_0000 + e;
      @(posedge clk); #1;
      if (mem_done) pulses.push_back(e);
    end
    cs = 1'b0; we = 1'b0;
    checks++;
    if (pulses.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses required 3", pulses.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (pulses[j] != 5 + j * (LATENCY + 2)) begin
          errors++;
          $display("FAIL b2b_pulse%0d: at edge %0d required %0d", j, pulses[j], 5 + j * (LATENCY + 2));
        end
      end
    end
    lat = 0;
    for (int i = 21; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 23) begin
      errors++;
      $display("FAIL b2b_tail: last pulse at edge %0d required 23", lat);
    end
    @(posedge clk); #1;
    do_op(32'd9, 32'h0, 1'b0, 1'b1, lat);
    check_dout("b2b_read9", 32'hC000_0013);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write_read();
    test_we_oe();
    test_wrap();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
